uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Byte-stream UART transmitter with an input FIFO. It sits directly downstream of the row compressor: it takes the compressor's one-cycle byte strobes (`o_frame`/`o_ready`), buffers them, and serialises them as 8N1 frames on the board's UART TX pin. It absorbs the compressor's bursty output so that bytes are not lost while a frame is on the line. Overflow is detected and reported rather than back-pressured, because the compressor has no stall input.

## Interface
- `ClkFreq`, default 50_000_000: CLK frequency in Hz.
- `BaudRate`, default 115_200: line rate in bit/s. `ClksPerBit = ClkFreq / BaudRate` (integer division, must be ≥ 2).
- `FifoDepth`, default 16: FIFO entries; must be a power of 2, ≥ 2.
- `CLK`  in  1  single system clock; all logic on posedge.
- `RST`  in  1  asynchronous, active-low reset.
- `i_byte`  in  8  byte to send; sampled only when `i_valid`=1.
- `i_valid`  in  1  one-cycle write strobe (driven by compressor `o_ready`).
- `o_tx`  out  1  UART line, idle high.
- `o_busy`  out  1  1 while the FSM is not in IDLE.
- `o_empty`  out  1  FIFO count == 0.
- `o_full`  out  1  FIFO count == FifoDepth.
- `o_count`  out  $clog2(FifoDepth)+1  bytes held in FIFO (excludes the byte in the shifter).
- `o_overflow`  out  1  sticky; set when a write is dropped; cleared only by reset.

## Operation
- **Reset values (asynchronous on RST=0):** `o_tx`=1, `o_busy`=0, `o_empty`=1, `o_full`=0, `o_count`=0, `o_overflow`=0. FIFO pointers, bit counter, baud counter and shifter are all zero; state is IDLE.
- **Write path:**
  - If `i_valid`=1 and `o_full`=0 (registered value at that edge), `i_byte` is stored at the write pointer and the pointer increments, wrapping mod FifoDepth.
  - If `i_valid`=1 and `o_full`=1, the byte is dropped and `o_overflow` is set. This holds even if a pop occurs in the same cycle.
- **Simultaneous write and pop when not full:** both are performed and `o_count` is unchanged.
- **FSM states: IDLE, START, DATA, STOP.**
  - **IDLE:** `o_tx`=1. If `o_empty`=0, pop the head into the shifter, clear the baud counter and go to START.
  - **START:** `o_tx`=0 for ClksPerBit cycles, then go to DATA with bit index 0.
  - **DATA:** `o_tx`=shifter[0] for ClksPerBit cycles, then shift right. After bit index 7 completes, go to STOP.
  - **STOP:** `o_tx`=1 for ClksPerBit cycles, then go to IDLE.
- **Bit order and framing:** LSB first; no parity; one stop bit.
- **Baud counter:** runs 0..ClksPerBit-1 and wraps. A bit period ends on the cycle the counter equals ClksPerBit-1.
- **`o_tx` glitching:** `o_tx` is registered and must not glitch.

## Timing
- **First-byte latency:** byte written at edge t into an empty FIFO with FSM in IDLE:
  - count becomes 1 after edge t;
  - pop happens at edge t+1;
  - `o_tx` falls after edge t+2.
  - Latency is 2 cycles.
- **Frame length:** 10·ClksPerBit cycles on the line.
- **Back-to-back frames:** exactly one IDLE cycle (`o_tx`=1) between consecutive frames, giving a period of 10·ClksPerBit+1 cycles.
- **`o_busy`:** rises in the same cycle as the start bit and falls in the cycle after the last STOP cycle.
- **Mid-operation reset:** RST asserted mid-frame immediately forces `o_tx`=1. Queued bytes are discarded. No partial frame resumes after release.
- **Capacity:** FifoDepth bytes in the FIFO plus 1 byte in the shifter.

## Test plan
Test parameters: ClkFreq=1_000_000, BaudRate=100_000 (ClksPerBit=10), FifoDepth=4.
- **Reset values:** hold RST=0 then release, with no writes → `o_tx`=1, `o_empty`=1, `o_count`=0, `o_overflow`=0, `o_busy`=0 for 100 cycles.
- **Single byte:** write 0xA5 once → `o_tx` low 2 cycles later for 10 cycles, then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high for 10 cycles; `o_busy` high for exactly 100 cycles.
- **Back-to-back bytes:** write 0x00, 0xFF, 0x3C on consecutive cycles → three frames decoded in order. Start bits are 101 cycles apart with one idle cycle between frames; `o_count` peaks at 2.
- **Overflow:** write 0x01..0x06 on 6 consecutive cycles → 0x01 goes to the shifter; 0x02..0x05 are queued (`o_full`=1, `o_count`=4); 0x06 is dropped and `o_overflow`=1. Line output is 0x01..0x05, and `o_overflow` stays 1 after the FIFO drains.
- **Wrap-around:** write 12 bytes, each 4 cycles after the previous frame starts → all 12 bytes are received intact and in order, and the pointers wrap 3 times.
- **Reset mid-frame:** assert RST during bit 3 of 0x55 with 2 bytes queued → `o_tx`=1 immediately and `o_count`=0. After release, no further frames are sent until a new write arrives.

Source files
------------

// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; overflow is flagged (sticky), never back-pressured.
// o_tx and o_busy are registered from the FSM state, so the line lags the state register by one cycle.
module uart_frame_tx #(
    parameter int ClkFreq   = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [7:0]                   i_byte,
    input  logic                         i_valid,
    output logic                         o_tx,
    output logic                         o_busy,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(FifoDepth):0]   o_count,
    output logic                         o_overflow
);

    localparam int CLKS_PER_BIT = ClkFreq / BaudRate;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(FifoDepth);
    localparam int NW           = AW + 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] COUNT_FULL = NW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FifoDepth];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [NW-1:0] count_reg, count_next;
    logic          overflow_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          busy_reg;
    logic          push, pop, full, empty, bit_done;

    assign full     = (count_reg == COUNT_FULL);
    assign empty    = (count_reg == '0);
    assign push     = i_valid && !full;
    assign bit_done = (baud_reg == BAUD_LAST);

    // Storage array has no reset so it can map onto RAM resources.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_byte;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + NW'(1);
            2'b01:   count_next = count_reg - NW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            // A write while full is lost even if a pop frees a slot on the same edge.
            if (i_valid && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next   = 1'b0;
                baud_next = bit_done ? '0 : baud_reg + CW'(1);
                if (bit_done) begin
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next   = shift_reg[0];
                baud_next = bit_done ? '0 : baud_reg + CW'(1);
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_next   = 1'b1;
                baud_next = bit_done ? '0 : baud_reg + CW'(1);
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= (state_reg != IDLE);
        end
    end

    assign o_tx       = tx_reg;
    assign o_busy     = busy_reg;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: a line decoder rebuilds bytes from o_tx and
// each scenario task compares them, plus timing and flags, against a queue-based model.
module tb_uart_frame_tx;

    localparam int C     = 10;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] i_byte = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_tx, o_busy, o_empty, o_full, o_overflow;
    logic [2:0] o_count;

    uart_frame_tx #(
        .ClkFreq  (1_000_000),
        .BaudRate (100_000),
        .FifoDepth(DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .i_byte    (i_byte),
        .i_valid   (i_valid),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_count   (o_count),
        .o_overflow(o_overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       stop_q[$];

    // Line decoder: samples each bit in the middle of its period, starting at a falling edge.
    bit         mon_active = 1'b0;
    int         mon_pos = 0;
    logic [7:0] mon_sh = 8'h00;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST !== 1'b1) begin
                mon_active = 1'b0;
            end else if (mon_active) begin
                mon_pos++;
                if (mon_pos >= C + C / 2 && mon_pos < 9 * C && (mon_pos - C / 2) % C == 0)
                    mon_sh[(mon_pos - C / 2) / C - 1] = o_tx;
                if (mon_pos == 9 * C + C / 2) begin
                    rx_q.push_back(mon_sh);
                    stop_q.push_back(o_tx);
                    $display("[TB] rx byte 0x%02h started at cycle %0d", mon_sh, start_q[$]);
                    mon_active = 1'b0;
                end
            end else if (o_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                start_q.push_back(cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic line_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_byte  = b;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        $display("[TB] wrote byte 0x%02h at cycle %0d", b, cyc);
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        repeat (3) step();
        RST = 1'b1;
        step();
        rx_q.delete();
        start_q.delete();
        stop_q.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        #2;
        RST = 1'b0;
        repeat (3) step();
        obs = {o_tx, o_busy, o_empty, o_full, o_overflow, o_count};
        tests++;
        if (obs !== 8'b1010_0000) begin
            fails++;
            $display("FAIL reset_hold: got %b expected %b", obs, 8'b1010_0000);
        end
        RST = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            obs = {o_tx, o_busy, o_empty, o_full, o_overflow, o_count};
            tests++;
            if (obs !== 8'b1010_0000) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, 8'b1010_0000);
            end
        end
        tests++;
        if (start_q.size() != 0) begin
            fails++;
            $display("FAIL reset_no_frame: got %0d frames expected 0", start_q.size());
        end
    endtask

    task automatic test_single();
        int wc, busy_cnt;
        logic exp_tx, exp_busy;
        apply_reset();
        write_byte(8'hA5);
        wc = cyc;
        tests++;
        if (o_count !== 3'd1 || o_empty !== 1'b0) begin
            fails++;
            $display("FAIL single_count: got count=%0d empty=%b expected 1/0", o_count, o_empty);
        end
        busy_cnt = 0;
        for (int j = 1; j <= 106; j++) begin
            step();
            exp_tx   = (j < 2 || j >= 102) ? 1'b1 : line_bit(8'hA5, j - 2);
            exp_busy = (j >= 2 && j < 102);
            if (o_busy === 1'b1) busy_cnt++;
            tests++;
            if (o_tx !== exp_tx || o_busy !== exp_busy) begin
                fails++;
                $display("FAIL single_wave j=%0d: got tx=%b busy=%b expected tx=%b busy=%b",
                         j, o_tx, o_busy, exp_tx, exp_busy);
            end
        end
        tests++;
        if (busy_cnt != 100) begin
            fails++;
            $display("FAIL single_busy_len: got %0d expected 100", busy_cnt);
        end
        tests++;
        if (rx_q.size() != 1 || start_q.size() != 1) begin
            fails++;
            $display("FAIL single_frames: got %0d expected 1", rx_q.size());
        end else if (rx_q[0] !== 8'hA5 || start_q[0] != wc + 2) begin
            fails++;
            $display("FAIL single_decode: got 0x%02h at %0d expected 0xa5 at %0d",
                     rx_q[0], start_q[0], wc + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int w0, peak, k;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h3C;
        apply_reset();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            write_byte(exp_b[i]);
            if (i == 0) w0 = cyc;
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        k = 0;
        while (rx_q.size() < 3 && k < 400) begin
            step();
            if (int'(o_count) > peak) peak = int'(o_count);
            k++;
        end
        tests++;
        if (rx_q.size() != 3) begin
            fails++;
            $display("FAIL b2b_frames: got %0d expected 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (rx_q[i] !== exp_b[i] || stop_q[i] !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_byte%0d: got 0x%02h stop=%b expected 0x%02h stop=1",
                             i, rx_q[i], stop_q[i], exp_b[i]);
                end
            end
            tests++;
            if (start_q[0] != w0 + 2) begin
                fails++;
                $display("FAIL b2b_latency: got %0d expected %0d", start_q[0] - w0, 2);
            end
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (start_q[i] - start_q[i-1] != 10 * C + 1) begin
                    fails++;
                    $display("FAIL b2b_period%0d: got %0d expected %0d",
                             i, start_q[i] - start_q[i-1], 10 * C + 1);
                end
            end
        end
        tests++;
        if (peak != 2) begin
            fails++;
            $display("FAIL b2b_peak_count: got %0d expected 2", peak);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] obs, exp_v;
        int exp_cnt[6];
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i + 1));
            obs   = {o_count, o_full, o_overflow};
            exp_v = {3'(exp_cnt[i]), (i >= 4) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL ovf_write%0d: got count/full/ovf=%b expected %b", i, obs, exp_v);
            end
        end
        wait_rx(5, 700);
        tests++;
        if (rx_q.size() != 5) begin
            fails++;
            $display("FAIL ovf_frames: got %0d expected 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (rx_q[i] !== 8'(i + 1)) begin
                    fails++;
                    $display("FAIL ovf_byte%0d: got 0x%02h expected 0x%02h", i, rx_q[i], 8'(i + 1));
                end
            end
        end
        repeat (2 * C) step();
        tests++;
        if (o_overflow !== 1'b1 || o_empty !== 1'b1 || start_q.size() != 5) begin
            fails++;
            $display("FAIL ovf_sticky: got ovf=%b empty=%b frames=%0d expected 1/1/5",
                     o_overflow, o_empty, start_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int k;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
            k = 0;
            while (start_q.size() < i + 1 && k < 150) begin
                step();
                k++;
            end
            repeat (3) step();
        end
        wait_rx(12, 300);
        tests++;
        if (rx_q.size() != 12) begin
            fails++;
            $display("FAIL wrap_frames: got %0d expected 12", rx_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                tests++;
                if (rx_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL wrap_byte%0d: got 0x%02h expected 0x%02h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        tests++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_overflow: got %b expected 0", o_overflow);
        end
    endtask

    task automatic test_random_burst();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b);
        end
        wait_rx(DEPTH + 1, 700);
        tests++;
        if (rx_q.size() != DEPTH + 1) begin
            fails++;
            $display("FAIL burst_frames: got %0d expected %0d", rx_q.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                tests++;
                if (rx_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL burst_byte%0d: got 0x%02h expected 0x%02h", i, rx_q[i], exp_q[i]);
                end
                if (i > 0) begin
                    tests++;
                    if (start_q[i] - start_q[i-1] != 10 * C + 1) begin
                        fails++;
                        $display("FAIL burst_period%0d: got %0d expected %0d",
                                 i, start_q[i] - start_q[i-1], 10 * C + 1);
                    end
                end
            end
        end
        tests++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL burst_overflow: got %b expected 0", o_overflow);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        int s, k;
        bit line_idle;
        apply_reset();
        write_byte(8'h55);
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        tests++;
        if (o_count !== 3'd2) begin
            fails++;
            $display("FAIL midrst_queued: got %0d expected 2", o_count);
        end
        k = 0;
        while (start_q.size() < 1 && k < 20) begin
            step();
            k++;
        end
        s = (start_q.size() > 0) ? start_q[0] : cyc;
        k = 0;
        while (cyc < s + 4 * C + C / 2 && k < 100) begin
            step();
            k++;
        end
        tests++;
        if (o_tx !== 1'b0) begin
            fails++;
            $display("FAIL midrst_bit3: got %b expected 0", o_tx);
        end
        RST = 1'b0;
        #1;
        tests++;
        if (o_tx !== 1'b1 || o_count !== 3'd0 || o_busy !== 1'b0 || o_empty !== 1'b1) begin
            fails++;
            $display("FAIL midrst_async: got tx=%b count=%0d busy=%b empty=%b expected 1/0/0/1",
                     o_tx, o_count, o_busy, o_empty);
        end
        repeat (3) step();
        RST = 1'b1;
        rx_q.delete();
        start_q.delete();
        stop_q.delete();
        line_idle = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (o_tx !== 1'b1 || o_busy !== 1'b0) line_idle = 1'b0;
        end
        tests++;
        if (!line_idle || start_q.size() != 0) begin
            fails++;
            $display("FAIL midrst_quiet: got idle=%b frames=%0d expected 1/0", line_idle, start_q.size());
        end
        b = 8'($urandom);
        write_byte(b);
        wait_rx(1, 150);
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            fails++;
            $display("FAIL midrst_resume: got %0d frames first=0x%02h expected 1 frame 0x%02h",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_random_burst();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
